data_mem: RTL

Data-memory responder for the MEMORY pipeline stage. It answers the stage's address/write/read-data interface with a word-addressed synchronous RAM and a fixed wait-state count. Completion is signalled by a one-cycle `mem_valid` pulse, which the hazard unit uses to stall and release the memory stage. It sits between the memory stage and the top level, in place of an ideal zero-latency memory.

---
 rtl/data_mem.sv | 116 +++++++++++
 1 files changed

// File: rtl/data_mem.sv
// data_mem: word-addressed RAM responder for the memory stage, fixed wait states, one-cycle valid pulse.
// Optional build macro DATA_MEM_RANDOM_WAIT_EN adds 0..3 LFSR-chosen extra wait states per access.
module data_mem #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  input  logic        mem_write,
  output logic        mem_valid,
  output logic [31:0] mem_read_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [4:0]            cnt;
  logic [4:0]            total_wait;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [31:0]           req_wdata;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           acc_wdata;
  logic                  acc_write;
  logic                  do_access;
  logic [31:0]           ram [DEPTH];

  // Byte-offset and aliasing bits of the address carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

`ifdef DATA_MEM_RANDOM_WAIT_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign total_wait = 5'(WAIT_CYCLES) + {3'b000, lfsr[1:0]};
`else
  assign total_wait = 5'(WAIT_CYCLES);
`endif

  // The access happens on the edge that enters RESP; with zero wait states that
  // edge is the IDLE sample itself, so the live inputs are used instead of the latches.
  always_comb begin
    do_access = 1'b0;
    acc_idx   = req_idx;
    acc_wdata = req_wdata;
    acc_write = req_write;
    if (state == IDLE && total_wait == 5'd0) begin
      do_access = 1'b1;
      acc_idx   = mem_addr[ADDR_WIDTH+1:2];
      acc_wdata = mem_write_data;
      acc_write = mem_write;
    end else if (state == WAIT && cnt <= 5'd1) begin
      do_access = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      mem_valid     <= 1'b0;
      mem_read_data <= '0;
      req_idx       <= '0;
      req_wdata     <= '0;
      req_write     <= 1'b0;
    end else begin
      mem_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_idx   <= mem_addr[ADDR_WIDTH+1:2];
          req_wdata <= mem_write_data;
          req_write <= mem_write;
          cnt       <= total_wait;
          if (total_wait == 5'd0) begin
            state     <= RESP;
            mem_valid <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 5'd1;
          if (cnt <= 5'd1) begin
            state     <= RESP;
            mem_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (do_access) begin
        mem_read_data <= acc_write ? acc_wdata : ram[acc_idx];
      end
    end
  end

  // Reset on the commit edge suppresses the store.
  always_ff @(posedge clk) begin
    if (!rst && do_access && acc_write) begin
      ram[acc_idx] <= acc_wdata;
    end
  end

endmodule
